// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
//   state_e     - controller states (IDLE, REQ, OUT, DROP, HALT)
//   INSTR_W     - instruction word width
//   IMM_W       - redirect immediate width (sign bit is the MSB)
//   ADDR_W_DEF  - default PC / instruction-memory byte-address width
// HALT is only reachable when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int IMM_W      = 21;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_OUT,
        ST_DROP,
        ST_HALT
    } state_e;

endpackage

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: combinational redirect-target adder.
//   redirect_jalr  in   1 = base is rs1_val (jalr), 0 = base is redirect_pc
//   redirect_pc    in   PC of the redirecting instruction
//   immediate      in   signed immediate, sign-extended before the add
//   rs1_val        in   register-file operand for jalr
//   target         out  redirect target, truncated to ADDR_W (wraps)
//   misalign       out  target bit 1 set (only meaningful with the trap enabled)
// Macro FETCH_MISALIGN_TRAP_EN: when defined, target passes through and
// misalign reports bit 1; when undefined, target[1:0] is forced to 0 and
// misalign is constant 0.
module fetch_target_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               redirect_jalr,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [INSTR_W-1:0] rs1_val,
    output logic [ADDR_W-1:0]  target,
    output logic               misalign
);

    logic [INSTR_W-1:0] base;
    logic [INSTR_W-1:0] imm_sext;
    logic [INSTR_W-1:0] sum;
    logic               unused_sum_bits;

    always_comb begin
        base     = redirect_jalr ? rs1_val : INSTR_W'(redirect_pc);
        imm_sext = {{(INSTR_W-IMM_W){immediate[IMM_W-1]}}, immediate};
        sum      = base + imm_sext;
        // jalr targets always have bit 0 cleared
        if (redirect_jalr) begin
            sum[0] = 1'b0;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        target   = sum[ADDR_W-1:0];
        misalign = sum[1];
`else
        target   = {sum[ADDR_W-1:2], 2'b00};
        misalign = 1'b0;
`endif
    end

    // High bits fall away with the modulo-2^ADDR_W wrap; low bits are
    // consumed only in the trap build.
    assign unused_sum_bits = ^{sum[INSTR_W-1:ADDR_W], sum[1:0]};

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, issues one
// instruction-memory request at a time (req/ack) and hands each fetched word
// to decode (valid/ready). Applies branch/jal/jalr redirects and discards
// responses made stale by a redirect.
//   clk, reset      clock; synchronous active-high reset
//   redirect_*      redirect request, base select, PC of redirecting instr
//   immediate       signed redirect immediate
//   rs1_val         jalr base register value
//   imem_req/addr   fetch request and byte address (held until imem_ack)
//   imem_ack/rdata  memory response
//   instr_valid     instr / instr_pc valid to decode
//   instr_ready     decode accepts instr this cycle
//   misalign_trap   one-cycle pulse on a misaligned redirect target
// Macro FETCH_MISALIGN_TRAP_EN: enables the misalign trap and HALT state.
// All outputs are registered.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic               redirect_jalr,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [INSTR_W-1:0] rs1_val,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               misalign_trap
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic               trap_q, trap_d;
    logic [ADDR_W-1:0]  target;
    logic               target_misalign;
    logic               redir;
    logic               take;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic               halt_pend_q, halt_pend_d;
`endif

    fetch_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target_calc (
        .redirect_jalr (redirect_jalr),
        .redirect_pc   (redirect_pc),
        .immediate     (immediate),
        .rs1_val       (rs1_val),
        .target        (target),
        .misalign      (target_misalign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            trap_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            trap_q      <= trap_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    // Next state and PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_pend_d = halt_pend_q;
        // Once a trap is pending, later redirects are ignored.
        redir = redirect_valid && (state_q != ST_HALT) && !halt_pend_q;
`else
        redir = redirect_valid;
`endif
        take   = redir && !target_misalign;
        trap_d = redir && target_misalign;

        if (take) begin
            pc_d = target;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    if (!take) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = ST_OUT;
                    end
                end else if (take) begin
                    state_d = ST_DROP;
                end
            end
            // Redirect wins over instr_ready; both lead back to REQ.
            ST_OUT:  if (take || instr_ready) state_d = ST_REQ;
            ST_DROP: if (imem_ack) state_d = ST_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // A pending trap overrides the normal flow: keep the PC, let any
        // in-flight request finish in DROP, then park in HALT.
        if (trap_d) begin
            halt_pend_d = 1'b1;
        end
        if (halt_pend_d) begin
            pc_d    = pc_q;
            state_d = (((state_q == ST_REQ) || (state_q == ST_DROP)) && !imem_ack)
                      ? ST_DROP : ST_HALT;
        end
`endif
    end

    // Registered outputs, derived from the upcoming state
    always_comb begin
        req_d      = (state_d == ST_REQ) || (state_d == ST_DROP);
        // DROP keeps the stale address on the bus until its ack.
        addr_d     = (state_d == ST_REQ) ? pc_d : addr_q;
        valid_d    = (state_d == ST_OUT);
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if ((state_q == ST_REQ) && (state_d == ST_OUT)) begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign instr_valid   = valid_q;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl. A scoreboard
// queue holds the words expected at decode; they are pushed when the bench
// acks a request that should be delivered and popped when instr_valid shows.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned-redirect step.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int AW = 10;

    typedef struct packed {
        logic [AW-1:0]      pc;
        logic [INSTR_W-1:0] word;
    } sb_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               redirect_valid = 1'b0;
    logic               redirect_jalr = 1'b0;
    logic [AW-1:0]      redirect_pc = '0;
    logic [IMM_W-1:0]   immediate = '0;
    logic [INSTR_W-1:0] rs1_val = '0;
    logic               imem_req;
    logic [AW-1:0]      imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      instr_pc;
    logic               instr_ready = 1'b0;
    logic               misalign_trap;

    int  n_vec = 0;
    int  n_err = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_ctrl #(
        .ADDR_W   (AW),
        .RESET_PC (10'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_jalr  (redirect_jalr),
        .redirect_pc    (redirect_pc),
        .immediate      (immediate),
        .rs1_val        (rs1_val),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .misalign_trap  (misalign_trap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req),      32'd0);
        chk({tag, "_addr"},  32'(imem_addr),     32'd0);
        chk({tag, "_valid"}, 32'(instr_valid),   32'd0);
        chk({tag, "_instr"}, instr,              32'd0);
        chk({tag, "_ipc"},   32'(instr_pc),      32'd0);
        chk({tag, "_trap"},  32'(misalign_trap), 32'd0);
    endtask

    // Compare the word on the decode port with the oldest expected entry.
    task automatic deliver(input string tag);
        sb_t e;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed word at decode expected none queued", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instr,         e.word);
            chk({tag, "_ipc"},   32'(instr_pc), 32'(e.pc));
        end
    endtask

    task automatic set_redir(input logic jalr, input logic [AW-1:0] rpc,
                             input logic [IMM_W-1:0] imm, input logic [31:0] rs1);
        redirect_valid = 1'b1;
        redirect_jalr  = jalr;
        redirect_pc    = rpc;
        immediate      = imm;
        rs1_val        = rs1;
    endtask

    task automatic clr_redir();
        redirect_valid = 1'b0;
    endtask

    // Entered at a negedge with the DUT in REQ; zero-wait ack, ready high.
    // Leaves at the negedge where the DUT is back in REQ.
    task automatic fetch_zw(input logic [AW-1:0] a);
        chk("zw_req",      32'(imem_req),    32'd1);
        chk("zw_addr",     32'(imem_addr),   32'(a));
        chk("zw_valid_lo", 32'(instr_valid), 32'd0);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        sb.push_back('{pc: a, word: mem_word(a)});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("zw_valid_hi", 32'(instr_valid), 32'd1);
        chk("zw_req_lo",   32'(imem_req),    32'd0);
        deliver("zw");
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait sequential fetch
        fetch_zw(10'd0);
        fetch_zw(10'd4);
        fetch_zw(10'd8);

        // Delayed ack with a branch redirect while the request is pending
        chk("dly_addr0", 32'(imem_addr), 32'd12);
        set_redir(1'b0, 10'd8, 21'd16, 32'd0);
        @(negedge clk);
        clr_redir();
        chk("drop_req",   32'(imem_req),  32'd1);
        chk("drop_addr1", 32'(imem_addr), 32'd12);
        @(negedge clk);
        chk("drop_addr2", 32'(imem_addr), 32'd12);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stale_valid", 32'(instr_valid), 32'd0);
        chk("dly_tgt",     32'(imem_addr),   32'd24);
        fetch_zw(10'd24);

        // jalr from OUT with decode stalled: presented word is dropped
        chk("jalr_addr0", 32'(imem_addr), 32'd28);
        imem_ack    = 1'b1;
        instr_ready = 1'b0;
        sb.push_back('{pc: 10'd28, word: mem_word(10'd28)});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("jalr_valid", 32'(instr_valid), 32'd1);
        deliver("jalr_pres");
        set_redir(1'b1, 10'd0, 21'd1, 32'h0000_0103);
        @(negedge clk);
        clr_redir();
        chk("jalr_valid_lo", 32'(instr_valid), 32'd0);
        chk("jalr_req",      32'(imem_req),    32'd1);
        chk("jalr_tgt",      32'(imem_addr),   32'h104);
        fetch_zw(10'h104);

        // Redirect and instr_ready in the same OUT cycle
        chk("rr_addr0", 32'(imem_addr), 32'h108);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        sb.push_back('{pc: 10'h108, word: mem_word(10'h108)});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rr_valid", 32'(instr_valid), 32'd1);
        deliver("rr_pres");
        set_redir(1'b0, 10'h3F0, 21'd12, 32'd0);
        @(negedge clk);
        clr_redir();
        chk("rr_valid_lo", 32'(instr_valid), 32'd0);
        chk("rr_tgt",      32'(imem_addr),   32'h3FC);
        // Sequential wrap 1020 -> 0
        fetch_zw(10'h3FC);
        fetch_zw(10'd0);

        // Reset mid-REQ
        chk("mreq_addr", 32'(imem_addr), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("rst_req");
        reset = 1'b0;
        @(negedge clk);
        chk("rel_req",  32'(imem_req),  32'd1);
        chk("rel_addr", 32'(imem_addr), 32'd0);

        // Reset mid-DROP: the pending target must be forgotten
        set_redir(1'b0, 10'd0, 21'h200, 32'd0);
        @(negedge clk);
        clr_redir();
        chk("mdrop_req",  32'(imem_req),  32'd1);
        chk("mdrop_addr", 32'(imem_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("rst_drop");
        reset = 1'b0;
        @(negedge clk);
        chk("rel_drop_addr", 32'(imem_addr), 32'd0);

        // Redirect during IDLE with a negative immediate (4 - 8 wraps)
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_redir(1'b0, 10'd4, 21'h1FFFF8, 32'd0);
        @(negedge clk);
        clr_redir();
        chk("idle_redir_req",  32'(imem_req),  32'd1);
        chk("idle_redir_addr", 32'(imem_addr), 32'h3FC);

        // jal with imm=+6 from pc 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_redir(1'b0, 10'd0, 21'd6, 32'd0);
        @(negedge clk);
        clr_redir();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_trap_hi", 32'(misalign_trap), 32'd1);
        chk("mis_req",     32'(imem_req),      32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_trap_lo", 32'(misalign_trap), 32'd0);
            chk("halt_req",     32'(imem_req),      32'd0);
            chk("halt_valid",   32'(instr_valid),   32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("halt_exit_req", 32'(imem_req), 32'd1);
`else
        chk("mis_trap_lo", 32'(misalign_trap), 32'd0);
        chk("mis_req",     32'(imem_req),      32'd1);
        chk("mis_addr",    32'(imem_addr),     32'd4);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
